// File: rtl/aux_stat_uart_if.sv
// aux_stat_uart_if: counter inputs, start request and UART/status outputs of the stats reporter
interface aux_stat_uart_if;
    logic        start;
    logic [31:0] cnt_cycle;
    logic [31:0] cnt_jump;
    logic [31:0] cnt_branch;
    logic [31:0] cnt_branched;
    logic [31:0] cnt_bubble;
    logic [31:0] cnt_load_use;
    logic        tx;
    logic        busy;
    logic        done;

    modport master (
        output start, cnt_cycle, cnt_jump, cnt_branch, cnt_branched, cnt_bubble, cnt_load_use,
        input  tx, busy, done
    );

    modport slave (
        input  start, cnt_cycle, cnt_jump, cnt_branch, cnt_branched, cnt_bubble, cnt_load_use,
        output tx, busy, done
    );
endinterface

// File: rtl/aux_stat_uart.sv
// aux_stat_uart: snapshots six perf counters and streams them as ASCII hex over 8N1 UART
module aux_stat_uart #(
    parameter int BaudCnt = 868
) (
    input logic clk,
    input logic rst_n,
    aux_stat_uart_if.slave bus
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_nx;
    logic [15:0]   baud;
    logic [2:0]    bit_idx, bit_nx;
    logic [5:0]    byte_idx, byte_nx;
    logic [191:0]  snap;
    logic          bit_end, done_nx, tx_nx;
    logic [2:0]    word;
    logic [3:0]    pos, nib;
    logic [5:0]    nib_idx;
    logic [7:0]    lsb, chr;

    assign bit_end = baud == 16'(BaudCnt - 1);

    // Character of the current byte: 9 bytes per counter (8 hex digits + space), then CR LF
    always_comb begin
        word    = 3'(byte_idx / 6'd9);
        pos     = 4'(byte_idx % 6'd9);
        nib_idx = (pos[3] || byte_idx >= 6'd54) ? 6'd0 : {word, 3'b000} + {2'b00, pos};
        lsb     = 8'd188 - {nib_idx, 2'b00};
        nib     = snap[lsb +: 4];
        chr     = byte_idx == 6'd54 ? 8'h0D :
                  byte_idx == 6'd55 ? 8'h0A :
                  pos == 4'd8       ? 8'h20 :
                  nib < 4'd10       ? 8'h30 + {4'h0, nib} : 8'h37 + {4'h0, nib};
    end

    // Next-state, index and serial-bit decode; tx is precomputed for the state being entered
    always_comb begin
        state_nx = state;
        bit_nx   = bit_idx;
        byte_nx  = byte_idx;
        done_nx  = 1'b0;
        case (state)
            IDLE:  if (bus.start) begin
                       state_nx = START;
                       byte_nx  = '0;
                   end
            START: if (bit_end) begin
                       state_nx = DATA;
                       bit_nx   = '0;
                   end
            DATA:  if (bit_end) begin
                       if (bit_idx == 3'd7) state_nx = STOP;
                       else bit_nx = bit_idx + 3'd1;
                   end
            STOP:  if (bit_end) begin
                       if (byte_idx == 6'd55) begin
                           state_nx = IDLE;
                           done_nx  = 1'b1;
                       end else begin
                           state_nx = START;
                           byte_nx  = byte_idx + 6'd1;
                       end
                   end
        endcase
        tx_nx = state_nx == DATA ? chr[bit_nx] : state_nx != START;
    end

    // State, baud timing, snapshot and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud     <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            snap     <= '0;
            bus.tx   <= 1'b1;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            state    <= state_nx;
            baud     <= (state == IDLE || bit_end) ? '0 : baud + 16'd1;
            bit_idx  <= bit_nx;
            byte_idx <= byte_nx;
            if (state == IDLE && bus.start)
                snap <= {bus.cnt_cycle, bus.cnt_jump, bus.cnt_branch,
                         bus.cnt_branched, bus.cnt_bubble, bus.cnt_load_use};
            bus.tx   <= tx_nx;
            bus.busy <= state_nx != IDLE;
            bus.done <= done_nx;
        end
    end
endmodule

// File: tb/tb_aux_stat_uart.sv
// tb_aux_stat_uart: randomized stimulus against a cycle-offset reference model of the report stream
module tb_aux_stat_uart;
    localparam int B = 4;
    localparam int R = 560 * B;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aux_stat_uart_if bus ();
    aux_stat_uart #(.BaudCnt(B)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit active = 1'b0;
    bit m_done = 1'b0;
    int a_cyc = 0;
    int done_cnt = 0;
    int last_done = 0;
    int busy_cycles = 0;
    int done_q[$];
    logic [7:0] mb[56];
    logic [7:0] rxb[56];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] hexc(logic [3:0] n);
        return n < 4'd10 ? 8'h30 + {4'h0, n} : 8'h41 + {4'h0, n} - 8'd10;
    endfunction

    // Reference model: state after each rising edge, derived from acceptance cycle and byte table
    always @(posedge clk) begin
        logic [31:0] vals[6];
        logic [31:0] t;
        cyc++;
        if (!rst_n) begin
            active = 1'b0;
            m_done = 1'b0;
        end else if (active && cyc - a_cyc == R) begin
            active = 1'b0;
            m_done = 1'b1;
        end else begin
            m_done = 1'b0;
            if (!active && bus.start) begin
                active = 1'b1;
                a_cyc = cyc;
                vals[0] = bus.cnt_cycle;
                vals[1] = bus.cnt_jump;
                vals[2] = bus.cnt_branch;
                vals[3] = bus.cnt_branched;
                vals[4] = bus.cnt_bubble;
                vals[5] = bus.cnt_load_use;
                for (int w = 0; w < 6; w++) begin
                    for (int d = 0; d < 8; d++) begin
                        t = vals[w] >> (28 - 4 * d);
                        mb[w * 9 + d] = hexc(t[3:0]);
                    end
                    mb[w * 9 + 8] = 8'h20;
                end
                mb[54] = 8'h0D;
                mb[55] = 8'h0A;
            end
        end
    end

    // Per-cycle compare of tx/busy/done against the model, plus mid-bit decoding of DUT bytes
    always @(negedge clk) begin
        int off, k, j;
        logic etx;
        if (active) begin
            off = cyc - a_cyc;
            k = off / (10 * B);
            j = (off / B) % 10;
            etx = j == 0 ? 1'b0 : j == 9 ? 1'b1 : mb[k][j - 1];
            if (j >= 1 && j <= 8 && off % B == B / 2) rxb[k][j - 1] = bus.tx;
        end else begin
            etx = 1'b1;
        end
        chk("tx", bus.tx, etx);
        chk("busy", bus.busy, active);
        chk("done", bus.done, m_done);
        if (bus.done === 1'b1) begin
            done_cnt++;
            last_done = cyc;
            done_q.push_back(cyc);
        end
        if (bus.busy === 1'b1) busy_cycles++;
    end

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_rand();
        bus.cnt_cycle = $urandom;
        bus.cnt_jump = $urandom;
        bus.cnt_branch = $urandom;
        bus.cnt_branched = $urandom;
        bus.cnt_bubble = $urandom;
        bus.cnt_load_use = $urandom;
    endtask

    task automatic set_all(logic [31:0] v);
        bus.cnt_cycle = v;
        bus.cnt_jump = v;
        bus.cnt_branch = v;
        bus.cnt_branched = v;
        bus.cnt_bubble = v;
        bus.cnt_load_use = v;
    endtask

    task automatic wait_done(string name);
        int n = 0;
        while (bus.done !== 1'b1 && n < R + 50) begin
            @(negedge clk);
            n++;
        end
        chk(name, bus.done, 1);
    endtask

    initial begin
        string exp1, s;
        bus.start = 1'b0;
        set_all(32'h0);
        tick(3);
        chk("rst_tx", bus.tx, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        rst_n = 1'b1;
        tick(2);

        bus.cnt_cycle = 32'h0000001F;
        done_cnt = 0;
        busy_cycles = 0;
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        wait_done("t1_done");
        tick(1);
        exp1 = "0000001F 00000000 00000000 00000000 00000000 00000000 \r\n";
        for (int i = 0; i < 56; i++) chk("t1_byte", rxb[i], exp1[i]);
        chk("t1_done_at", last_done - a_cyc, R);
        chk("t1_busy_cycles", busy_cycles, R);
        chk("t1_done_cnt", done_cnt, 1);

        set_rand();
        bus.cnt_cycle = 32'h11111111;
        bus.cnt_jump = 32'hDEADBEEF;
        bus.cnt_load_use = 32'h0123ABCD;
        done_cnt = 0;
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        set_all(32'hFFFFFFFF);
        tick(99);
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        tick(899);
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        wait_done("t2_done");
        tick(1);
        s = "11111111";
        for (int i = 0; i < 8; i++) chk("t2_cycle_byte", rxb[i], s[i]);
        s = "DEADBEEF";
        for (int i = 0; i < 8; i++) chk("t2_jump_byte", rxb[9 + i], s[i]);
        s = "0123ABCD";
        for (int i = 0; i < 8; i++) chk("t2_load_use_byte", rxb[45 + i], s[i]);
        chk("t2_done_cnt", done_cnt, 1);
        chk("t2_done_at", last_done - a_cyc, R);

        set_rand();
        done_cnt = 0;
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        tick(56);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        chk("t3_rst_tx", bus.tx, 1);
        chk("t3_rst_busy", bus.busy, 0);
        chk("t3_rst_done", bus.done, 0);
        tick(5);
        chk("t3_no_done", done_cnt, 0);
        set_rand();
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        set_rand();
        wait_done("t3_done");
        tick(1);
        chk("t3_done_cnt", done_cnt, 1);

        set_rand();
        done_q.delete();
        bus.start = 1'b1;
        for (int i = 0; i < 2 * R + 2; i++) begin
            tick(1);
            set_rand();
        end
        bus.start = 1'b0;
        tick(3);
        chk("t4_done_pulses", done_q.size(), 2);
        if (done_q.size() == 2) chk("t4_done_gap", done_q[1] - done_q[0], R + 1);

        for (int r = 0; r < 3; r++) begin
            set_rand();
            tick($urandom_range(0, 5));
            bus.start = 1'b1;
            tick(1);
            bus.start = 1'b0;
            tick($urandom_range(1, 300));
            set_rand();
            wait_done("t5_done");
            tick($urandom_range(1, 4));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/aux_stat_uart.md
# aux_stat_uart

Downstream consumer of the six 32-bit performance counters (cycle, jump, branch, branched, bubble, load-use) produced at the top level. On a start pulse it snapshots all six counters and streams them out of a UART TX pin as ASCII hex, so a host terminal can log benchmark statistics without reading the seven-segment display. It runs in the board clock domain, alongside the display and clock dividers, and has no effect on the core.

## Interface
- BaudCnt, 868, board-clock cycles per UART bit (868 = 100 MHz / 115200); legal range 2..65535.
- clk  input  1  board clock; the only clock. All logic is rising-edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  request one report; level-sampled, acted on only while busy=0.
- cnt_cycle  input  32  cycle counter.
- cnt_jump  input  32  jump counter.
- cnt_branch  input  32  branch counter.
- cnt_branched  input  32  taken-branch counter.
- cnt_bubble  input  32  bubble counter.
- cnt_load_use  input  32  load-use counter.
- tx  output  1  UART serial out, 8N1, idle high.
- busy  output  1  high from acceptance until the report completes.
- done  output  1  one-cycle pulse at report completion.

## Operation
- Report format is 56 bytes. For each counter, in port order cycle, jump, branch, branched, bubble, load_use:
  - 8 ASCII hex digits, most-significant nibble first;
  - then a space (0x20).
- After the sixth counter: CR (0x0D), then LF (0x0A).
- Hex encoding: nibble 0–9 maps to 0x30+n; nibble 10–15 maps to 0x41+n−10 (uppercase).
- Frame format is 8N1:
  - start bit 0;
  - data bits LSB first;
  - one stop bit 1;
  - no parity;
  - frames are sent back-to-back with no idle gap.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE to START on start=1. On the same edge, all six counters are latched into a 192-bit snapshot, the byte index is cleared to 0, busy is set to 1 and tx is driven to 0.
  - START to DATA after BaudCnt cycles. The bit index is cleared to 0.
  - DATA stays in DATA for 8 bits, each lasting BaudCnt cycles. The next state is STOP after bit 7.
  - STOP: if byte index < 55, increment the index and go to START. If byte index = 55, go to IDLE, clear busy, pulse done for 1 cycle, and tx stays 1.
- Snapshot rule: all bytes come from the snapshot. Input changes after acceptance never alter the report.
- start while busy=1 is ignored. The request is not queued and the current report is unaffected.
- Holding start=1 continuously starts a new report on the edge after done. The new report gets a fresh snapshot.
- Baud counter runs 0..BaudCnt−1. It is cleared on every state entry, so every bit is exactly BaudCnt cycles long.
- tx is registered, with no combinational path from any input to tx.

## Timing
- Reset values: tx=1, busy=0, done=0, state IDLE, all counters 0.
- Reset has priority over everything, including mid-frame. On the reset edge tx returns to 1 and the partial byte is abandoned. done is not asserted.
- Let edge A be the edge at which start is accepted.
  - tx=0 and busy=1 are visible right after A.
  - Byte k bit j (start bit = position 0, data bits = 1..8, stop bit = 9) is driven during cycles [A + (10k+j)·BaudCnt, A + (10k+j+1)·BaudCnt).
- Completion happens at edge A + 560·BaudCnt.
  - done=1 for exactly that one cycle; busy=0 from the same edge.
  - The earliest next acceptance is edge A + 560·BaudCnt + 1.
- Counter arithmetic: baud counter is 16 bits, bit index is 3 bits, byte index is 6 bits. None of them wraps within a report.

## Test plan
- BaudCnt=4; cnt_cycle=0x0000001F, others 0; one start pulse:
  - decoded bytes are "0000001F 00000000 00000000 00000000 00000000 00000000 \r\n";
  - the first start bit is low for exactly 4 cycles;
  - done pulses at A+2240;
  - busy is high for cycles A..A+2239.
- cnt_jump=0xDEADBEEF, cnt_load_use=0x0123ABCD:
  - bytes 9–16 are 0x44,0x45,0x41,0x44,0x42,0x45,0x45,0x46;
  - bytes 45–52 are "0123ABCD".
- Snapshot: accept a start with cnt_cycle=0x11111111, then set all inputs to 0xFFFFFFFF one cycle later → report still shows 0x11111111 for cycle and the originally applied values for the other five.
- Start pulses at A+100 and A+1000 → ignored; exactly 56 frames are sent, and a single done pulse occurs at A+2240.
- rst_n=0 for one cycle at A+57 (mid-data of byte 1):
  - tx=1, busy=0, done=0 from the next cycle;
  - a start after reset produces a complete, correct 56-byte report.
- start held high with BaudCnt=2 → second report begins at edge A+1121 with tx=0, busy stays 0 only at cycle A+1120, and two done pulses occur, 1121 cycles apart.
